skinny_sbox8_inv_domd_hs: RTL and testbench

SKINNY_SBOX8_INV_DOMD_HS -- requirements
Module: skinny_sbox8_inv_domd_hs

---
 rtl/skinny_sbox8_inv_domd_hs_if.sv | 24 ++
 rtl/skinny_sbox8_inv_domd_hs.sv | 129 ++++++++++++
 tb/tb_skinny_sbox8_inv_domd_hs.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/skinny_sbox8_inv_domd_hs_if.sv
// Handshake bundle for the masked SKINNY-128 inverse S-box; d is the protection order.
// Share j of a byte occupies bits [8*j +: 8] of si/so.
interface skinny_sbox8_inv_domd_hs_if #(
    parameter int d = 2
);
    logic [8*(d+1)-1:0]     si;
    logic                   in_valid;
    logic                   in_ready;
    logic [8*d*(d+1)/2-1:0] r;
    logic                   r_req;
    logic [8*(d+1)-1:0]     so;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output si, in_valid, r, out_ready,
        input  in_ready, r_req, so, out_valid
    );

    modport slave (
        input  si, in_valid, r, out_ready,
        output in_ready, r_req, so, out_valid
    );
endinterface

// File: rtl/skinny_sbox8_inv_domd_hs.sv
// Masked (DOM-indep, d+1 shares) SKINNY-128 inverse S-box, four registered gadget layers.
// Optional macro SKINNY_SBOX8_INV_ZEROIZE_EN clears all share registers on the DONE->IDLE handshake.
module skinny_sbox8_inv_domd_hs #(
    parameter int d = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    skinny_sbox8_inv_domd_hs_if.slave bus
);
    localparam int NS = d + 1;
    localparam int NR = d * (d + 1) / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Indexed by gadget k (k7 first): result bit position and layer that loads it.
    localparam logic [7:0][2:0] OUT_BIT = {3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd7, 3'd3, 3'd5};
    localparam logic [7:0][1:0] LAYER   = {2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

    logic [1:0]                 state;
    logic [1:0]                 cnt;
    logic [NS-1:0][7:0]         o_q;
    logic [7:0][NS-1:0][NS-1:0] term_q;
    logic [7:0][NS-1:0][NS-1:0] term_d;
    logic [NS-1:0][7:0]         b_sh;
    logic [7:0][NS-1:0]         x_op;
    logic [7:0][NS-1:0]         y_op;
    logic [7:0][NS-1:0]         z_op;
    logic [7:0][NR-1:0]         r_sl;
    logic                       a_bit;
    logic                       b_bit;

    function automatic int unsigned pair_idx(input int unsigned lo, input int unsigned hi);
        return lo * NS - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    assign r_sl = bus.r;

    // Share compression: each output share XORs only registered terms of its own row.
    always_comb begin
        b_sh = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned s = 0; s < NS; s++) begin
                b_sh[s][OUT_BIT[k]] = ^term_q[k][s];
            end
        end
    end

    always_comb begin
        x_op = '0;
        y_op = '0;
        z_op = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            {x_op[0][s], y_op[0][s], z_op[0][s]} = {o_q[s][6], o_q[s][5], o_q[s][7]};
            {x_op[1][s], y_op[1][s], z_op[1][s]} = {o_q[s][7], o_q[s][6], o_q[s][4]};
            {x_op[2][s], y_op[2][s], z_op[2][s]} = {o_q[s][2], o_q[s][7], o_q[s][1]};
            {x_op[3][s], y_op[3][s], z_op[3][s]} = {o_q[s][3], o_q[s][1], o_q[s][0]};
            {x_op[4][s], y_op[4][s], z_op[4][s]} = {o_q[s][5], b_sh[s][3], o_q[s][3]};
            {x_op[5][s], y_op[5][s], z_op[5][s]} = {b_sh[s][3], b_sh[s][2], o_q[s][5]};
            {x_op[6][s], y_op[6][s], z_op[6][s]} = {b_sh[s][2], b_sh[s][1], o_q[s][2]};
            {x_op[7][s], y_op[7][s], z_op[7][s]} = {b_sh[s][7], b_sh[s][6], o_q[s][6]};
        end
    end

    // nor(x,y) = AND of complements; complementing share 0 alone inverts the masked value.
    always_comb begin
        term_d = '0;
        a_bit  = 1'b0;
        b_bit  = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned i = 0; i < NS; i++) begin
                for (int unsigned j = 0; j < NS; j++) begin
                    a_bit = x_op[k][i] ^ (i == 0);
                    b_bit = y_op[k][j] ^ (j == 0);
                    if (i == j)
                        term_d[k][i][j] = (a_bit & b_bit) ^ z_op[k][i];
                    else if (i < j)
                        term_d[k][i][j] = (a_bit & b_bit) ^ r_sl[k][pair_idx(i, j)];
                    else
                        term_d[k][i][j] = (a_bit & b_bit) ^ r_sl[k][pair_idx(j, i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            o_q    <= '0;
            term_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        o_q   <= bus.si;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int unsigned k = 0; k < 8; k++) begin
                        if (LAYER[k] == cnt)
                            term_q[k] <= term_d[k];
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
`ifdef SKINNY_SBOX8_INV_ZEROIZE_EN
                        o_q    <= '0;
                        term_q <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.r_req     = (state == BUSY);
    assign bus.so        = b_sh;
endmodule

// File: tb/tb_skinny_sbox8_inv_domd_hs.sv
// Self-checking bench for skinny_sbox8_inv_domd_hs (d=2): known vectors, exhaustive sweep,
// DONE back-pressure, mid-operation reset; honours SKINNY_SBOX8_INV_ZEROIZE_EN.
module tb_skinny_sbox8_inv_domd_hs;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] inv_tab [256];
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] x;
        logic [7:0] want;
        int         hold;
    } vec_t;
    vec_t vecs [4];

    skinny_sbox8_inv_domd_hs_if #(.d(2)) bus ();

    skinny_sbox8_inv_domd_hs #(.d(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward SKINNY-128 S8: four NOR/XOR rounds with bit permutation, last round only swaps bits 1/2.
    function automatic logic [7:0] s8(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int it = 0; it < 4; it++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (it < 3)
                x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            else
                x = {x[7], x[6], x[5], x[4], x[3], x[1], x[2], x[0]};
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] unmask(input logic [23:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16];
    endfunction

    task automatic do_op(input logic [7:0] x, input logic [7:0] want, input int hold);
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  exp_v;
        logic [23:0] so_hold;
        logic [23:0] so_idle;
        int          cyc;
        int          rq;
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        bus.si = {x ^ s0 ^ s1, s1, s0};
        bus.in_valid = 1'b1;
        sb.push_back(want);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.si = 24'($urandom);
        cyc = 0;
        rq  = 0;
        while (!bus.out_valid && cyc < 16) begin
            if (bus.r_req) rq++;
            bus.r = 24'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'd4);
        check("r_req_cycles", 64'(rq), 64'd4);
        exp_v = sb.pop_front();
        if (!bus.out_valid) return;
        check("result", 64'(unmask(bus.so)), 64'(exp_v));
        so_hold = bus.so;
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'b1;
            bus.si = 24'($urandom);
            @(posedge clk); #1;
            check("hold_so_stable", 64'(bus.so), 64'(so_hold));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("no_pass_through", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("released_out_valid", 64'(bus.out_valid), 64'd0);
        check("released_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef SKINNY_SBOX8_INV_ZEROIZE_EN
        check("zeroized_so", 64'(bus.so), 64'd0);
`else
        check("retained_so", 64'(bus.so), 64'(so_hold));
`endif
        so_idle = bus.so;
        @(posedge clk); #1;
        check("idle_so_stable", 64'(bus.so), 64'(so_idle));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] dropped;
        int         ov_seen;
        checks   = 0;
        failures = 0;
        for (int v = 0; v < 256; v++) inv_tab[s8(v[7:0])] = v[7:0];

        vecs[0] = '{8'h65, 8'h00, 0};
        vecs[1] = '{8'h4C, 8'h01, 3};
        vecs[2] = '{8'hFF, 8'hFF, 0};
        vecs[3] = '{8'h65, 8'h00, 10};

        rst_n         = 1'b0;
        bus.si        = '0;
        bus.in_valid  = 1'b0;
        bus.r         = '0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_so", 64'(bus.so), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_r_req", 64'(bus.r_req), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) do_op(vecs[i].x, vecs[i].want, vecs[i].hold);

        for (int v = 0; v < 256; v++)
            do_op(v[7:0], inv_tab[v[7:0]], int'($urandom_range(0, 2)));

        // Abort with cnt = 2: two BUSY edges after the accepting edge.
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        bus.si = {8'h65 ^ s0 ^ s1, s1, s0};
        bus.in_valid = 1'b1;
        sb.push_back(8'h00);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.r = 24'($urandom);
            @(posedge clk); #1;
        end
        check("abort_in_busy", 64'(bus.r_req), 64'd1);
        rst_n = 1'b0;
        #1;
        dropped = sb.pop_back();
        check("abort_so", 64'(bus.so), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_r_req", 64'(bus.r_req), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen = 1;
        end
        check("abort_no_out_valid", 64'(ov_seen), 64'd0);
        check("abort_dropped_entry", 64'(dropped), 64'h00);
        do_op(8'h4C, 8'h01, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
